exe_alu_seq: RTL and testbench
==============================

# exe_alu_seq

Sequential execute-stage ALU that consumes the 3-bit ALU control code and sign qualifier produced by the ALU control decoder, together with two 32-bit operands. It registers every result behind a valid/ready handshake. Shifts run iteratively, one bit per cycle, to save area. It sits between operand selection and writeback/branch resolution.

## Interface
- XLEN, 32, operand and result width; only 32 is supported.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- valid_i  in  1  operation request valid.
- ready_o  out  1  block can accept a request.
- ALUctrl_i  in  3  operation code from the shared ALU define set: ADD, SUB, SLL, SLT_SLTU, XOR, SRL_SRA, OR, AND.
- sign_i  in  1  qualifier:
  - SLT_SLTU: 1 = signed compare, 0 = unsigned.
  - SRL_SRA: 1 = arithmetic shift, 0 = logical.
  - Ignored for all other codes.
- src1_i  in  32  operand A.
- src2_i  in  32  operand B; shift amount is src2_i[4:0].
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- result_o  out  32  registered result.
- zero_o  out  1  result_o == 0, derived combinationally from the result register.

## Operation
- FSM has three states: IDLE, SHIFT, DONE.
  - ready_o = (state == IDLE).
  - valid_o = (state == DONE).
- Accept occurs when valid_i && ready_o. On accept, ALUctrl_i, sign_i, src1_i and the shift amount are latched. Inputs are don't-care after accept.
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^32.
  - SLT_SLTU returns 32'd1 if A < B, else 32'd0. The compare is two's-complement when sign_i = 1 and unsigned when sign_i = 0.
  - XOR, OR and AND are bitwise.
- Non-shift op: the result is written on the accept edge, and the FSM goes IDLE -> DONE.
- Shift op with shamt == 0: result = src1_i, and the FSM goes IDLE -> DONE.
- Shift op with shamt > 0:
  - On accept, the working register is loaded with src1_i, the counter is loaded with shamt, and the FSM goes IDLE -> SHIFT.
  - Each SHIFT cycle shifts by one bit and decrements the counter.
  - SLL fills with 0. SRL fills with 0. SRA fills with bit 31 of the working register.
  - When the counter reaches 1, the final shift is done and the FSM goes SHIFT -> DONE.
- DONE: result_o and valid_o are held stable until ready_i = 1. On that edge the FSM goes DONE -> IDLE.
- Backpressure: while valid_o = 1 and ready_i = 0, result_o and zero_o must not change.
- Unknown ALUctrl_i codes cannot occur because all 8 codes are defined. The default branch performs ADD.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, so ready_o = 1 during and after reset.
  - valid_o = 0, result_o = 32'd0, zero_o = 1, shift counter = 0.
- Latency, accept edge to valid_o high:
  - 1 cycle for non-shift ops and for shifts with shamt = 0.
  - 1 + shamt cycles for shifts with shamt > 0, so 32 cycles at most (shamt = 31).
- Throughput: at most one op per 2 cycles. There is no accept in DONE, even if ready_i = 1 on the same edge.
- ready_o is low from the cycle after accept until the cycle after the result handshake.
- If ready_i is already high when valid_o rises, the handshake completes on the first DONE edge.
- Reset mid-operation: an in-flight SHIFT or pending DONE result is discarded, and no valid_o is produced for it.
- valid_i while ready_o = 0 is ignored. Upstream must hold the request until it is accepted.

## Configuration
- EXE_ALU_BARREL_SHIFT_EN defined:
  - Shifts use a single-cycle barrel shifter and complete IDLE -> DONE with 1-cycle latency.
  - The SHIFT state and the shift counter are not synthesized.
- Undefined: iterative one-bit-per-cycle shifting as described above.
- Handshake, reset values and non-shift behaviour are identical in both builds.

## Test plan
- Reset, then ADD A=32'hFFFF_FFFF, B=32'd1, ready_i=1:
  - One cycle later valid_o=1, result_o=0, zero_o=1.
  - ready_o returns high the cycle after.
- Compare op, A=32'hFFFF_FFFE (-2), B=32'd3:
  - SLT_SLTU sign_i=1 -> result 32'd1.
  - Same operands with sign_i=0 -> result 32'd0.
- SRL_SRA sign_i=1, A=32'h8000_0000, B=32'd4:
  - Iterative build: valid_o after exactly 5 cycles, result 32'hF800_0000.
  - Same op with sign_i=0 -> 32'h0800_0000.
  - EXE_ALU_BARREL_SHIFT_EN build: 1 cycle.
- SLL A=32'd1, B=32'd0 -> 1 cycle, result 32'd1. SLL A=32'd1, B=32'd31 -> 32 cycles, result 32'h8000_0000.
- SUB A=5, B=7 with ready_i=0 for 3 cycles:
  - result_o stays 32'hFFFF_FFFE with valid_o high, and ready_o stays low.
  - A new valid_i during this time is not accepted.
- SRL A=32'hF0, B=31: assert rst_ni low mid-shift, cycle 10.
  - Immediately valid_o=0, result_o=0, ready_o=1.
  - No stale result appears after release.

Source files
------------

// File: rtl/exe_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : exe_alu_seq
// Description : Sequential execute-stage ALU with valid/ready handshake on
//               both sides and a registered result. Shifts run iteratively,
//               one bit per cycle. Defining EXE_ALU_BARREL_SHIFT_EN replaces
//               the iterative shifter with a single-cycle barrel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module exe_alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      ALUctrl_i,
    input  logic            sign_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o
);

    // ALU operation codes shared with the ALU control decoder
    localparam logic [2:0] c_ALU_ADD      = 3'd0;
    localparam logic [2:0] c_ALU_SUB      = 3'd1;
    localparam logic [2:0] c_ALU_SLL      = 3'd2;
    localparam logic [2:0] c_ALU_SLT_SLTU = 3'd3;
    localparam logic [2:0] c_ALU_XOR      = 3'd4;
    localparam logic [2:0] c_ALU_SRL_SRA  = 3'd5;
    localparam logic [2:0] c_ALU_OR       = 3'd6;
    localparam logic [2:0] c_ALU_AND      = 3'd7;

    // FSM encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DONE  = 2'd2;
`ifndef EXE_ALU_BARREL_SHIFT_EN
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
`endif

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] w_alu;
    logic [4:0]      w_shamt;
    logic            w_accept;

`ifndef EXE_ALU_BARREL_SHIFT_EN
    // Iterative shifter state: r_result doubles as the working register
    logic [4:0]      r_cnt;
    logic [2:0]      r_op;
    logic            r_sign;
    logic            w_is_shift;
    logic [XLEN-1:0] w_shift1;
`endif

    assign w_shamt  = src2_i[4:0];
    assign w_accept = valid_i && (r_state == c_ST_IDLE);

`ifndef EXE_ALU_BARREL_SHIFT_EN
    assign w_is_shift = (ALUctrl_i == c_ALU_SLL) || (ALUctrl_i == c_ALU_SRL_SRA);

    // One-bit shift step; right shifts fill with the MSB only when arithmetic
    always_comb begin
        w_shift1 = r_result;
        if (r_op == c_ALU_SLL) begin
            w_shift1 = {r_result[XLEN-2:0], 1'b0};
        end else begin
            w_shift1 = {r_sign & r_result[XLEN-1], r_result[XLEN-1:1]};
        end
    end
`endif

    // Single-cycle result for the accepted operation (shift seed in iterative build)
    always_comb begin
        w_alu = src1_i + src2_i;
        case (ALUctrl_i)
            c_ALU_ADD:      w_alu = src1_i + src2_i;
            c_ALU_SUB:      w_alu = src1_i - src2_i;
            c_ALU_SLT_SLTU: begin
                if (sign_i) begin
                    w_alu = {{(XLEN-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
                end else begin
                    w_alu = {{(XLEN-1){1'b0}}, (src1_i < src2_i)};
                end
            end
            c_ALU_XOR:      w_alu = src1_i ^ src2_i;
            c_ALU_OR:       w_alu = src1_i | src2_i;
            c_ALU_AND:      w_alu = src1_i & src2_i;
`ifdef EXE_ALU_BARREL_SHIFT_EN
            c_ALU_SLL:      w_alu = src1_i << w_shamt;
            c_ALU_SRL_SRA: begin
                if (sign_i) begin
                    w_alu = $unsigned($signed(src1_i) >>> w_shamt);
                end else begin
                    w_alu = src1_i >> w_shamt;
                end
            end
`else
            c_ALU_SLL:      w_alu = src1_i;
            c_ALU_SRL_SRA:  w_alu = src1_i;
`endif
            default:        w_alu = src1_i + src2_i;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; no accept is possible outside IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
`ifdef EXE_ALU_BARREL_SHIFT_EN
                    w_state_next = c_ST_DONE;
`else
                    if (w_is_shift && (w_shamt != 5'd0)) begin
                        w_state_next = c_ST_SHIFT;
                    end else begin
                        w_state_next = c_ST_DONE;
                    end
`endif
                end
            end
`ifndef EXE_ALU_BARREL_SHIFT_EN
            c_ST_SHIFT: begin
                if (r_cnt == 5'd1) begin
                    w_state_next = c_ST_DONE;
                end
            end
`endif
            c_ST_DONE: begin
                if (ready_i) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        if (r_state == c_ST_IDLE) begin
            ready_o = 1'b1;
        end
        if (r_state == c_ST_DONE) begin
            valid_o = 1'b1;
        end
    end

    // Result / working register; only written on accept or while shifting,
    // so it is frozen throughout DONE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_result <= '0;
`ifndef EXE_ALU_BARREL_SHIFT_EN
            r_cnt    <= 5'd0;
            r_op     <= c_ALU_ADD;
            r_sign   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_result <= w_alu;
`ifndef EXE_ALU_BARREL_SHIFT_EN
            r_cnt    <= w_is_shift ? w_shamt : 5'd0;
            r_op     <= ALUctrl_i;
            r_sign   <= sign_i;
`endif
        end
`ifndef EXE_ALU_BARREL_SHIFT_EN
        else if (r_state == c_ST_SHIFT) begin
            r_result <= w_shift1;
            r_cnt    <= r_cnt - 5'd1;
        end
`endif
    end

    assign result_o = r_result;
    assign zero_o   = (r_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_exe_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_exe_alu_seq
// Description : Self-checking bench for exe_alu_seq: directed vector table,
//               randomized ops against a behavioural model, reset corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_alu_seq;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SLL = 3'd2;
    localparam logic [2:0] OP_SLT = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SRX = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_AND = 3'd7;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  ALUctrl_i;
    logic        sign_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        zero_o;

    int n_checks = 0;
    int n_fail   = 0;

    exe_alu_seq #(.XLEN(32)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALUctrl_i (ALUctrl_i),
        .sign_i    (sign_i),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .zero_o    (zero_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  op;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain arithmetic on the operation's definition
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic sg,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        longint sa, sb;
        sh = b[4:0];
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_SLL: return a << sh;
            OP_SLT: return sg ? ((sa < sb) ? 32'd1 : 32'd0)
                              : ((longint'(a) < longint'(b)) ? 32'd1 : 32'd0);
            OP_XOR: return a ^ b;
            OP_SRX: return sg ? 32'($signed(a) >>> sh) : (a >> sh);
            OP_OR:  return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] b);
`ifdef EXE_ALU_BARREL_SHIFT_EN
        return 1;
`else
        if ((op == OP_SLL || op == OP_SRX) && b[4:0] != 5'd0) return 1 + int'(b[4:0]);
        return 1;
`endif
    endfunction

    // Issue one op, measure latency, check result, backpressure and handshake
    task automatic run_op(input string name, input logic [2:0] op, input logic sg,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int hold);
        int  cycles;
        logic rdy_bad;
        @(negedge clk_i);
        check({name, " ready_o before accept"}, {31'd0, ready_o}, 32'd1);
        valid_i   = 1'b1;
        ALUctrl_i = op;
        sign_i    = sg;
        src1_i    = a;
        src2_i    = b;
        ready_i   = (hold == 0);
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i   = 1'b0;
        ALUctrl_i = 3'($urandom);
        src1_i    = $urandom;
        src2_i    = $urandom;
        cycles    = 1;
        rdy_bad   = 1'b0;
        while (!valid_o && cycles < 40) begin
            if (ready_o) rdy_bad = 1'b1;
            @(posedge clk_i);
            @(negedge clk_i);
            cycles++;
        end
        if (ready_o) rdy_bad = 1'b1;
        check({name, " latency"}, 32'(cycles), 32'(lat));
        check({name, " result"}, result_o, exp);
        check({name, " zero"}, {31'd0, zero_o}, {31'd0, (exp == 32'd0)});
        check({name, " ready_o low while busy"}, {31'd0, rdy_bad}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            valid_i   = 1'b1;
            ALUctrl_i = OP_ADD;
            src1_i    = $urandom;
            src2_i    = $urandom;
            @(posedge clk_i);
            @(negedge clk_i);
            check({name, " held result"}, result_o, exp);
            check({name, " held valid/ready/zero"}, {29'd0, valid_o, ready_o, zero_o},
                  {29'd0, 1'b1, 1'b0, (exp == 32'd0)});
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check({name, " after handshake valid/ready"}, {30'd0, valid_o, ready_o}, 32'b01);
    endtask

    vec_t vecs[10];

    initial begin
        int   lat;
        logic seen;
        logic [2:0]  rop;
        logic        rsg;
        logic [31:0] ra, rb;

        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        ALUctrl_i = 3'd0; sign_i = 1'b0; src1_i = '0; src2_i = '0;

        vecs[0] = '{OP_ADD, 1'b0, 32'hFFFF_FFFF, 32'd1,  32'h0000_0000, 1,  0};
        vecs[1] = '{OP_SLT, 1'b1, 32'hFFFF_FFFE, 32'd3,  32'h0000_0001, 1,  0};
        vecs[2] = '{OP_SLT, 1'b0, 32'hFFFF_FFFE, 32'd3,  32'h0000_0000, 1,  1};
        vecs[3] = '{OP_SRX, 1'b1, 32'h8000_0000, 32'd4,  32'hF800_0000, 5,  0};
        vecs[4] = '{OP_SRX, 1'b0, 32'h8000_0000, 32'd4,  32'h0800_0000, 5,  0};
        vecs[5] = '{OP_SLL, 1'b0, 32'd1,         32'd0,  32'h0000_0001, 1,  0};
        vecs[6] = '{OP_SLL, 1'b0, 32'd1,         32'd31, 32'h8000_0000, 32, 0};
        vecs[7] = '{OP_SUB, 1'b0, 32'd5,         32'd7,  32'hFFFF_FFFE, 1,  3};
        vecs[8] = '{OP_XOR, 1'b0, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 1, 0};
        vecs[9] = '{OP_AND, 1'b1, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000, 1, 2};

        // Reset state while reset is asserted
        #12;
        check("reset ready_o",  {31'd0, ready_o}, 32'd1);
        check("reset valid_o",  {31'd0, valid_o}, 32'd0);
        check("reset result_o", result_o, 32'd0);
        check("reset zero_o",   {31'd0, zero_o}, 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            lat = vecs[i].lat;
`ifdef EXE_ALU_BARREL_SHIFT_EN
            lat = 1;
`endif
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sg, vecs[i].a, vecs[i].b,
                   vecs[i].exp, lat, vecs[i].hold);
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            rsg = 1'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            if (i % 7 == 0) ra = rb;
            run_op($sformatf("rnd%0d", i), rop, rsg, ra, rb, ref_alu(rop, rsg, ra, rb),
                   ref_lat(rop, rb), $urandom_range(0, 2));
        end

        // Reset in the middle of a long shift discards the operation
        @(negedge clk_i);
        valid_i = 1'b1; ALUctrl_i = OP_SRX; sign_i = 1'b0;
        src1_i = 32'h0000_00F0; src2_i = 32'd31; ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("midreset valid_o",  {31'd0, valid_o}, 32'd0);
        check("midreset result_o", result_o, 32'd0);
        check("midreset ready_o",  {31'd0, ready_o}, 32'd1);
        check("midreset zero_o",   {31'd0, zero_o}, 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (valid_o || !ready_o) seen = 1'b1;
        end
        check("no stale result after reset", {31'd0, seen}, 32'd0);

        // Block is usable again after the aborted operation
        run_op("post-reset", OP_OR, 1'b0, 32'hF0F0_0000, 32'h0000_F0F0, 32'hF0F0_F0F0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
